// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg
// Shared definitions for the shift issue/retire sequencer:
//   - shifter format codes (lsr, lsl, asr, ror32)
//   - FSM state encoding
//   - helpers that decide whether a request can skip the shifter and
//     that map the 8-bit request count onto the 6-bit shifter count
package shift_seq_pkg;

  localparam logic [2:0] FMT_LSR = 3'b000;
  localparam logic [2:0] FMT_LSL = 3'b001;
  localparam logic [2:0] FMT_ASR = 3'b010;
  localparam logic [2:0] FMT_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // hit  : the result is known without running the shifter
  // fill : value replicated across every result bit when hit is set
  typedef struct packed {
    logic hit;
    logic fill;
  } bypass_t;

  // Linear shifts by WIDTH or more shift everything out, so the result
  // is either all zeros or, for asr, all copies of the sign bit.
  // Rotates never bypass because their count wraps modulo 32.
  function automatic bypass_t bypass_calc(input logic [2:0] fmt,
                                          input logic [7:0] cnt,
                                          input logic       sign,
                                          input int         width);
    bypass_t r;
    r.hit  = ((fmt & FMT_ROR) == 3'b000) && (int'(cnt) >= width);
    r.fill = r.hit && (fmt == FMT_ASR) && sign;
    return r;
  endfunction

  // Rotates use the low five bits of the count; linear shifts that reach
  // the shifter are already known to be below WIDTH (at most 64).
  function automatic logic [5:0] map_cnt(input logic [2:0] fmt,
                                         input logic [7:0] cnt);
    logic [5:0] c;
    if ((fmt & FMT_ROR) == FMT_ROR) c = {1'b0, cnt[4:0]};
    else                            c = cnt[5:0];
    return c;
  endfunction

endpackage

// File: rtl/shift_req_buf.sv
// shift_req_buf
// One-entry request holding register placed in front of the sequencer
// when SHIFT_SEQ_SKID_EN is defined.  It lets the ALU hand over one more
// request while the sequencer is still working on, or holding the
// response of, the previous one.
//
// Ports:
//   clk, arstn         clock, asynchronous active-low reset
//   push               load fmt/cnt/a/tag into the entry
//   pop                the sequencer consumed the entry
//   fmt, cnt, a, tag   request fields to capture
//   buf_valid          entry holds a request
//   buf_fmt .. buf_tag stored request fields
module shift_req_buf
  #(parameter int WIDTH = 32,
    parameter int TAGW  = 4)
  (
    input  logic             clk,
    input  logic             arstn,
    input  logic             push,
    input  logic             pop,
    input  logic [2:0]       fmt,
    input  logic [7:0]       cnt,
    input  logic [WIDTH-1:0] a,
    input  logic [TAGW-1:0]  tag,
    output logic             buf_valid,
    output logic [2:0]       buf_fmt,
    output logic [7:0]       buf_cnt,
    output logic [WIDTH-1:0] buf_a,
    output logic [TAGW-1:0]  buf_tag
  );

  // A push on the same edge as a pop replaces the entry, so the buffer
  // stays full and arrival order is kept.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      buf_valid <= 1'b0;
      buf_fmt   <= '0;
      buf_cnt   <= '0;
      buf_a     <= '0;
      buf_tag   <= '0;
    end else begin
      if (push) begin
        buf_valid <= 1'b1;
        buf_fmt   <= fmt;
        buf_cnt   <= cnt;
        buf_a     <= a;
        buf_tag   <= tag;
      end else if (pop) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shift_seq.sv
// shift_seq
// Issue/retire stage in front of the iterative shifter (ishift).  Takes
// shift requests from the ALU, answers out-of-range linear shifts
// directly, otherwise pulses the shifter, waits for it to finish and
// holds the result with the request tag until the consumer takes it.
//
// Configuration macro: SHIFT_SEQ_SKID_EN adds a one-entry request buffer
// so a second request can be accepted while one is in flight.
//
// Ports:
//   clk, arstn            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake from the ALU
//   req_fmt, req_cnt      format code and 8-bit shift count
//   req_a, req_tag        operand and opaque tag
//   rsp_valid/rsp_ready   held response handshake
//   rsp_y, rsp_tag        result and tag of the request it belongs to
//   sh_go                 one-cycle start pulse to the shifter
//   sh_fmt, sh_cnt, sh_a  registered command to the shifter
//   sh_busy, sh_y         shifter status and result
//   idle                  FSM in IDLE with no response held
module shift_seq
  import shift_seq_pkg::*;
  #(parameter int WIDTH = 32,
    parameter int TAGW  = 4)
  (
    input  logic             clk,
    input  logic             arstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_fmt,
    input  logic [7:0]       req_cnt,
    input  logic [WIDTH-1:0] req_a,
    input  logic [TAGW-1:0]  req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             sh_go,
    output logic [2:0]       sh_fmt,
    output logic [5:0]       sh_cnt,
    output logic [WIDTH-1:0] sh_a,
    input  logic             sh_busy,
    input  logic [WIDTH-1:0] sh_y,
    output logic             idle
  );

  state_t           state;
  state_t           state_nxt;
  logic             run_q;
  logic [TAGW-1:0]  tag_q;
  logic             transfer;
  logic             issue_valid;
  logic [2:0]       issue_fmt;
  logic [7:0]       issue_cnt;
  logic [WIDTH-1:0] issue_a;
  logic [TAGW-1:0]  issue_tag;
  bypass_t          byp;

  assign transfer = req_valid && req_ready;

`ifdef SHIFT_SEQ_SKID_EN
  logic             can_issue;
  logic             buf_push;
  logic             buf_pop;
  logic             buf_valid;
  logic [2:0]       buf_fmt;
  logic [7:0]       buf_cnt;
  logic [WIDTH-1:0] buf_a;
  logic [TAGW-1:0]  buf_tag;

  // The sequencer may start a new request on the edge that retires the
  // held response.  A buffered request always goes first; an arriving
  // request goes straight through only when nothing is buffered and the
  // sequencer can take it, otherwise it is parked in the buffer.
  assign can_issue   = (state == ST_IDLE) && (!rsp_valid || rsp_ready);
  assign buf_pop     = can_issue && buf_valid;
  assign buf_push    = transfer && !(can_issue && !buf_valid);
  assign issue_valid = can_issue && (buf_valid || transfer);
  assign issue_fmt   = buf_valid ? buf_fmt : req_fmt;
  assign issue_cnt   = buf_valid ? buf_cnt : req_cnt;
  assign issue_a     = buf_valid ? buf_a   : req_a;
  assign issue_tag   = buf_valid ? buf_tag : req_tag;

  shift_req_buf #(.WIDTH(WIDTH), .TAGW(TAGW)) u_buf (
    .clk       (clk),
    .arstn     (arstn),
    .push      (buf_push),
    .pop       (buf_pop),
    .fmt       (req_fmt),
    .cnt       (req_cnt),
    .a         (req_a),
    .tag       (req_tag),
    .buf_valid (buf_valid),
    .buf_fmt   (buf_fmt),
    .buf_cnt   (buf_cnt),
    .buf_a     (buf_a),
    .buf_tag   (buf_tag)
  );
`else
  assign issue_valid = transfer;
  assign issue_fmt   = req_fmt;
  assign issue_cnt   = req_cnt;
  assign issue_a     = req_a;
  assign issue_tag   = req_tag;
`endif

  assign byp = bypass_calc(issue_fmt, issue_cnt, issue_a[WIDTH-1], WIDTH);

  // req_ready must read low while reset is held, even though the FSM
  // already sits in IDLE; run_q goes high on the first edge after release.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: bypassed requests never leave IDLE; shifter
  // requests spend one cycle in SETTLE so the shifter has seen sh_go
  // before its busy flag is trusted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (issue_valid && !byp.hit) state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_WAIT;
      ST_WAIT:   if (!sh_busy) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    idle = (state == ST_IDLE) && !rsp_valid;
`ifdef SHIFT_SEQ_SKID_EN
    req_ready = run_q && !buf_valid;
`else
    req_ready = run_q && idle;
`endif
  end

  // Registered shifter command and held response.  Clearing the response
  // is written before the loads so that a load on the same edge wins.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sh_go     <= 1'b0;
      sh_fmt    <= '0;
      sh_cnt    <= '0;
      sh_a      <= '0;
      tag_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_tag   <= '0;
    end else begin
      sh_go <= 1'b0;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if ((state == ST_IDLE) && issue_valid) begin
        if (byp.hit) begin
          rsp_valid <= 1'b1;
          rsp_y     <= {WIDTH{byp.fill}};
          rsp_tag   <= issue_tag;
        end else begin
          sh_go  <= 1'b1;
          sh_fmt <= issue_fmt;
          sh_cnt <= map_cnt(issue_fmt, issue_cnt);
          sh_a   <= issue_a;
          tag_q  <= issue_tag;
        end
      end
      if ((state == ST_WAIT) && !sh_busy) begin
        rsp_valid <= 1'b1;
        rsp_y     <= sh_y;
        rsp_tag   <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq
// Self-checking bench for shift_seq at WIDTH=32.  A small model of the
// iterative shifter answers sh_go pulses; expected results come from a
// bit-level description of each shift format applied to the original
// request.  Directed cases cover clamping, rotate wrap, backpressure and
// reset mid-operation, followed by randomized requests.
module tb_shift_seq;
  import shift_seq_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAGW  = 4;

  logic             clk = 1'b0;
  logic             arstn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_fmt = '0;
  logic [7:0]       req_cnt = '0;
  logic [WIDTH-1:0] req_a = '0;
  logic [TAGW-1:0]  req_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_y;
  logic [TAGW-1:0]  rsp_tag;
  logic             sh_go;
  logic [2:0]       sh_fmt;
  logic [5:0]       sh_cnt;
  logic [WIDTH-1:0] sh_a;
  logic             sh_busy;
  logic [WIDTH-1:0] sh_y;
  logic             idle;

  int checks = 0;
  int passes = 0;
  int goCount = 0;
  int goWhileBusy = 0;
  int busyLeft = 0;
  logic [WIDTH-1:0] shY = '0;

  always #5 clk = ~clk;

  shift_seq #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk       (clk),
    .arstn     (arstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fmt   (req_fmt),
    .req_cnt   (req_cnt),
    .req_a     (req_a),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_tag   (rsp_tag),
    .sh_go     (sh_go),
    .sh_fmt    (sh_fmt),
    .sh_cnt    (sh_cnt),
    .sh_a      (sh_a),
    .sh_busy   (sh_busy),
    .sh_y      (sh_y),
    .idle      (idle)
  );

  // Shifter result as the ishift block would produce it from its command.
  function automatic logic [WIDTH-1:0] ishiftModel(input logic [2:0] f,
                                                   input logic [5:0] c,
                                                   input logic [WIDTH-1:0] a);
    logic [63:0] d;
    logic [WIDTH-1:0] y;
    d = {a, a};
    if (f[2])               y = 32'(d >> c[4:0]);
    else if (f == FMT_ASR)  y = $signed(a) >>> c;
    else if (f[0])          y = a << c;
    else                    y = a >> c;
    return y;
  endfunction

  // Shifter timing: busy for floor(c/6) + c mod 6 cycles after it sees go.
  assign sh_busy = (busyLeft != 0);
  assign sh_y    = shY;

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      busyLeft <= 0;
      shY      <= '0;
    end else if (sh_go) begin
      busyLeft <= int'(sh_cnt) / 6 + int'(sh_cnt) % 6;
      shY      <= ishiftModel(sh_fmt, sh_cnt, sh_a);
    end else if (busyLeft != 0) begin
      busyLeft <= busyLeft - 1;
    end
  end

  always @(posedge clk) begin
    if (sh_go) goCount <= goCount + 1;
    if (sh_go && sh_busy) goWhileBusy <= goWhileBusy + 1;
  end

  // Request-level reference: each result bit is picked directly from the
  // operand according to the format and the full 8-bit count.
  function automatic logic [31:0] refResult(input logic [2:0] fmt,
                                            input logic [7:0] cnt,
                                            input logic [31:0] a);
    logic [31:0] y;
    int n;
    n = int'(cnt);
    y = '0;
    for (int i = 0; i < 32; i++) begin
      if (fmt[2])             y[i] = a[(i + n) % 32];
      else if (fmt == FMT_ASR) y[i] = (i + n < 32) ? a[i + n] : a[31];
      else if (fmt[0])        y[i] = (i >= n) ? a[i - n] : 1'b0;
      else                    y[i] = (i + n < 32) ? a[i + n] : 1'b0;
    end
    return y;
  endfunction

  function automatic int refLatency(input logic [2:0] fmt, input logic [7:0] cnt);
    int c;
    if (!fmt[2] && int'(cnt) >= 32) return 1;
    c = fmt[2] ? int'(cnt) % 32 : int'(cnt);
    return 3 + c / 6 + c % 6;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, "_req_ready"}, 64'(req_ready), 64'(0));
    checkOutput({phase, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    checkOutput({phase, "_rsp_y"},     64'(rsp_y),     64'(0));
    checkOutput({phase, "_rsp_tag"},   64'(rsp_tag),   64'(0));
    checkOutput({phase, "_sh_go"},     64'(sh_go),     64'(0));
    checkOutput({phase, "_sh_fmt"},    64'(sh_fmt),    64'(0));
    checkOutput({phase, "_sh_cnt"},    64'(sh_cnt),    64'(0));
    checkOutput({phase, "_sh_a"},      64'(sh_a),      64'(0));
    checkOutput({phase, "_idle"},      64'(idle),      64'(1));
  endtask

  // One complete request: transfer, wait for the response, optionally
  // hold it under backpressure, then consume it.
  task automatic applyStimulus(input logic [2:0] fmt, input logic [7:0] cnt,
                               input logic [31:0] a, input logic [3:0] tag,
                               input int holdCycles);
    logic [31:0] wantY;
    int wantLat;
    int lat;
    int goBefore;
    logic isByp;
    logic stable;
    logic sawReady;
    logic [31:0] heldY;
    logic [3:0] heldTag;
    wantY   = refResult(fmt, cnt, a);
    wantLat = refLatency(fmt, cnt);
    isByp   = (wantLat == 1);

    @(negedge clk);
    checkOutput("req_ready_before", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_fmt   = fmt;
    req_cnt   = cnt;
    req_a     = a;
    req_tag   = tag;
    goBefore  = goCount;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(wantLat));
    checkOutput("rsp_y", 64'(rsp_y), 64'(wantY));
    checkOutput("rsp_tag", 64'(rsp_tag), 64'(tag));
    checkOutput("sh_go_pulses", 64'(goCount - goBefore), isByp ? 64'(0) : 64'(1));
    if (!isByp)
      checkOutput("sh_cnt", 64'(sh_cnt),
                  64'(fmt[2] ? int'(cnt) % 32 : int'(cnt)));

    heldY    = rsp_y;
    heldTag  = rsp_tag;
    stable   = 1'b1;
    sawReady = 1'b0;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_y !== heldY || rsp_tag !== heldTag) stable = 1'b0;
      if (req_ready) sawReady = 1'b1;
    end
    if (holdCycles > 0) begin
      checkOutput("hold_stable", 64'(stable), 64'(1));
`ifndef SHIFT_SEQ_SKID_EN
      checkOutput("hold_req_ready", 64'(sawReady), 64'(0));
`endif
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_drop", 64'(rsp_valid), 64'(0));
    checkOutput("req_ready_after", 64'(req_ready), 64'(1));
  endtask

`ifdef SHIFT_SEQ_SKID_EN
  task automatic skidBackToBack();
    logic [31:0] a1;
    logic [31:0] a2;
    int n;
    a1 = $urandom;
    a2 = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_fmt = FMT_LSL; req_cnt = 8'd2; req_a = a1; req_tag = 4'd3;
    @(posedge clk); #1;
    checkOutput("skid_ready_second", 64'(req_ready), 64'(1));
    req_fmt = FMT_LSR; req_cnt = 8'd1; req_a = a2; req_tag = 4'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    checkOutput("skid_tag_first", 64'(rsp_tag), 64'(3));
    checkOutput("skid_y_first", 64'(rsp_y), 64'(refResult(FMT_LSL, 8'd2, a1)));
    @(posedge clk); #1;
    n = 0;
    while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    checkOutput("skid_tag_second", 64'(rsp_tag), 64'(5));
    checkOutput("skid_y_second", 64'(rsp_y), 64'(refResult(FMT_LSR, 8'd1, a2)));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] f;
    logic [7:0] c;
    int quiet;

    #12;
    checkResetValues("reset");
    @(negedge clk);
    arstn = 1'b1;

    applyStimulus(FMT_LSR, 8'd4,   32'h8000_0000, 4'd1, 0);
    applyStimulus(FMT_ASR, 8'd40,  32'h8000_0000, 4'd2, 0);
    applyStimulus(FMT_LSL, 8'd200, 32'hDEAD_BEEF, 4'd3, 0);
    applyStimulus(FMT_ROR, 8'd33,  32'h0000_0001, 4'd4, 0);
    applyStimulus(FMT_LSL, 8'd13,  32'h0000_0001, 4'd5, 0);
    applyStimulus(FMT_ASR, 8'd31,  32'h7000_0000, 4'd6, 0);
    applyStimulus(FMT_LSR, 8'd32,  32'hFFFF_FFFF, 4'd7, 0);
    applyStimulus(FMT_ROR, 8'd0,   32'h1234_5678, 4'd8, 0);
    applyStimulus(FMT_LSR, 8'd7,   32'hCAFE_F00D, 4'd9, 10);

    // Reset while the sequencer waits on a long shift.
    @(negedge clk);
    req_valid = 1'b1; req_fmt = FMT_LSR; req_cnt = 8'd31;
    req_a = 32'hFFFF_0000; req_tag = 4'hA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    arstn = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    arstn = 1'b1;
    quiet = 1;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid || sh_go) quiet = 0;
    end
    checkOutput("dropped_request", 64'(quiet), 64'(1));
    applyStimulus(FMT_LSR, 8'd0, 32'h5A5A_1234, 4'hB, 0);

`ifdef SHIFT_SEQ_SKID_EN
    skidBackToBack();
`endif

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 40));
      applyStimulus(f, c, $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)));
    end

    checkOutput("go_while_busy", 64'(goWhileBusy), 64'(0));

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
